lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: none; widths fixed at 32-bit address and data.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low; the block is in reset while rst=0 at a posedge clk.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  LSU can accept a request this cycle.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle pulse; request complete.
REQ-011 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 resp_err  output  1  illegal funct3 for the access type.
REQ-013 mem_addr  output  32  word-aligned address to the data memory.
REQ-014 mem_wdata  output  32  lane-shifted write data.
REQ-015 mem_wmask  output  4  byte-lane write enables.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_rdata  input  32  memory read word, combinational from mem_addr; valid only while mem_we=0.

Function
REQ-018 FSM states IDLE, ACC1, ACC2, RESP; req_ready=1 only in IDLE.
REQ-019 Acceptance: req_valid&&req_ready at a posedge latches we, funct3, addr and wdata, then transitions IDLE->ACC1.
REQ-020 Misalignment rule: H misaligned iff addr[1:0]==3; W misaligned iff addr[1:0]!=0; B never misaligned.
REQ-021 Error rule: loads with funct3 in {011,110,111} and stores with funct3 not in {000,001,010} are errors.
REQ-022 Error path: IDLE->ACC1->RESP with mem_we=0 and mem_wmask=0 in ACC1; resp_err=1 and resp_rdata=0.
REQ-023 ACC1: mem_addr={addr[31:2],2'b00}; next state is ACC2 if misaligned, else RESP.
REQ-024 ACC2: mem_addr={addr[31:2],2'b00}+4, modulo 2^32, so 0xFFFFFFFC+4 wraps to 0x00000000; next state is RESP.
REQ-025 Store lanes: with o=addr[1:0] and n=size in bytes, ACC1 mask bits o..min(o+n-1,3) are set and mem_wdata=wdata<<(8*o); ACC2 mask has the low (o+n-4) bits set and mem_wdata=wdata>>(8*(4-o)).
REQ-026 mem_we=1 only in ACC1/ACC2 of a legal store, and only for the duration of that state.
REQ-027 Loads: ACC1 captures mem_rdata>>(8*o); ACC2 ORs in mem_rdata<<(8*(4-o)); the result is then truncated to n bytes and sign-extended (B/H) or zero-extended (BU/HU).
REQ-028 Outside ACC1/ACC2, the memory outputs are: mem_we=0, mem_wmask=0, mem_addr=0 and mem_wdata=0.
REQ-029 RESP: resp_valid=1 for exactly one cycle, then the FSM returns to IDLE; there is no response backpressure.
REQ-030 resp_rdata and resp_err are registered and hold their value until the next RESP.
REQ-031 Latency from acceptance edge to resp_valid: 2 cycles aligned or error; 3 cycles misaligned.
REQ-032 Back-to-back: a new request may be accepted in the first IDLE cycle after RESP; throughput is at most one request per 3 cycles.

Reset
REQ-033 On reset the state is IDLE, resp_valid=0, resp_rdata=0, resp_err=0, all mem_* outputs are 0, and req_ready=1 on the first cycle after reset is released.
REQ-034 Reset mid-operation (ACC1/ACC2/RESP) aborts the request: no further mem_we and no resp_valid.

Structure
REQ-035 Package lsu_pkg holds the funct3 localparams, the state enum lsu_state_t, and the size-decode function.
REQ-036 Sub-module lsu_ldext (combinational) performs load truncation and extension from {merged word, funct3}.

Verification
REQ-037 Aligned SW addr=0x10, wdata=0xDEADBEEF -> ACC1 has mem_addr=0x10, wmask=1111, mem_we=1; resp_valid 2 cycles after acceptance; memory word 4 = 0xDEADBEEF.
REQ-038 LB addr=0x13 with word 0x10=0x80AABBCC -> resp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-039 Misaligned SW addr=0x12, wdata=0x11223344 -> ACC1: addr 0x10, wmask 1100, wdata 0x33440000; ACC2: addr 0x14, wmask 0011, wdata 0x00001122; resp 3 cycles after acceptance.
REQ-040 Misaligned LH addr=0x17 with byte 0x17=0x34 and byte 0x18=0x92 -> resp_rdata=0xFFFF9234.
REQ-041 SW with funct3=011 -> mem_we never asserted; resp_err=1 and resp_rdata=0 at latency 2.
REQ-042 Reset asserted during ACC1 of a misaligned store -> no ACC2 write, no resp_valid; req_ready=1 after reset is released.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and access decode helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} lsu_state_t;
  function automatic logic [2:0] lsu_size(input logic [2:0] f3);
    return 3'd1 << f3[1:0];
  endfunction
  function automatic logic lsu_err(input logic we, input logic [2:0] f3);
    return we ? !(f3 == F3_B || f3 == F3_H || f3 == F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
  endfunction
  function automatic logic lsu_mis(input logic [2:0] f3, input logic [1:0] off);
    return f3[1:0] == 2'b01 ? off == 2'b11 : f3[1:0] == 2'b10 ? off != 2'b00 : 1'b0;
  endfunction
endpackage

// File: rtl/lsu_ldext.sv
// lsu_ldext: truncates a merged load word to the access size and sign/zero extends it
module lsu_ldext
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  always_comb
    o_data = i_funct3 == F3_B  ? {{24{i_word[7]}}, i_word[7:0]} :
             i_funct3 == F3_H  ? {{16{i_word[15]}}, i_word[15:0]} :
             i_funct3 == F3_BU ? {24'b0, i_word[7:0]} :
             i_funct3 == F3_HU ? {16'b0, i_word[15:0]} : i_word;
endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit splitting misaligned accesses into two word accesses
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);
  lsu_state_t  r_state;
  logic        r_we, r_err, r_mis, r_resp_valid, r_resp_err, r_mem_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [3:0]  r_mem_wmask, r_hi_mask;
  logic [31:0] r_rd, r_resp_rdata, r_mem_addr, r_mem_wdata, r_hi_data;
  logic        w_err, w_st;
  logic [2:0]  w_size;
  logic [3:0]  w_base;
  logic [7:0]  w_mask;
  logic [63:0] w_data;
  logic [31:0] w_merged, w_ext;
  // The request is lane-shifted once at acceptance; the upper half feeds the second word access.
  always_comb begin
    w_err = lsu_err(req_we, req_funct3);
    w_st = req_we && !w_err;
    w_size = lsu_size(req_funct3);
    w_base = w_size == 3'd1 ? 4'b0001 : w_size == 3'd2 ? 4'b0011 : 4'b1111;
    w_mask = {4'b0, w_base} << req_addr[1:0];
    w_data = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
    w_merged = r_state == ACC1 ? mem_rdata >> {r_off, 3'b000} :
               r_rd | (mem_rdata << {3'd4 - {1'b0, r_off}, 3'b000});
  end
  lsu_ldext u_ldext (
    .i_word  (w_merged),
    .i_funct3(r_f3),
    .o_data  (w_ext)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= IDLE;
      r_we <= 1'b0;
      r_err <= 1'b0;
      r_mis <= 1'b0;
      r_f3 <= 3'b0;
      r_off <= 2'b0;
      r_rd <= 32'b0;
      r_hi_mask <= 4'b0;
      r_hi_data <= 32'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'b0;
      r_resp_err <= 1'b0;
      r_mem_addr <= 32'b0;
      r_mem_wdata <= 32'b0;
      r_mem_wmask <= 4'b0;
      r_mem_we <= 1'b0;
    end else
      case (r_state)
        IDLE:
          if (req_valid) begin
            r_state <= ACC1;
            r_we <= req_we;
            r_f3 <= req_funct3;
            r_off <= req_addr[1:0];
            r_err <= w_err;
            r_mis <= !w_err && lsu_mis(req_funct3, req_addr[1:0]);
            r_mem_addr <= {req_addr[31:2], 2'b00};
            r_mem_we <= w_st;
            r_mem_wmask <= w_st ? w_mask[3:0] : 4'b0;
            r_mem_wdata <= w_st ? w_data[31:0] : 32'b0;
            r_hi_mask <= w_mask[7:4];
            r_hi_data <= w_data[63:32];
          end
        ACC1, ACC2:
          if (r_state == ACC1 && r_mis) begin
            r_state <= ACC2;
            r_mem_addr <= r_mem_addr + 32'd4;
            r_mem_wmask <= r_we ? r_hi_mask : 4'b0;
            r_mem_wdata <= r_we ? r_hi_data : 32'b0;
            r_rd <= w_merged;
          end else begin
            r_state <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= (r_we || r_err) ? 32'b0 : w_ext;
            r_resp_err <= r_err;
            r_mem_addr <= 32'b0;
            r_mem_wdata <= 32'b0;
            r_mem_wmask <= 4'b0;
            r_mem_we <= 1'b0;
          end
        RESP: begin
          r_state <= IDLE;
          r_resp_valid <= 1'b0;
        end
      endcase
  assign req_ready = r_state == IDLE;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err = r_resp_err;
  assign mem_addr = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;
  assign mem_we = r_mem_we;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized load/store traffic checked against a byte-addressed reference memory
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic [7:0]  ref_mem [0:255];
  logic [31:0] dut_mem [0:63];
  logic [31:0] cap_addr [1:2];
  logic [31:0] cap_wdata [1:2];
  logic [3:0]  cap_mask [1:2];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // 256-byte data memory seen by the DUT; higher address bits alias
  assign mem_rdata = dut_mem[mem_addr[7:2]];
  always @(posedge clk)
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) dut_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}], ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]};
  endfunction

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int n, o, lat, nwe;
    logic err, mis;
    logic [31:0] v, exp_rd;
    logic [3:0] m1, m2;
    logic [7:0] a2;
    err = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    o = int'(addr[1:0]);
    mis = !err && (o + n > 4);
    v = 0;
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[8'(addr + 32'(i))]) << (8 * i);
    exp_rd = (err || we) ? 32'h0 : n == 4 ? v :
             n == 2 ? (f3[2] ? v & 32'hFFFF : {{16{v[15]}}, v[15:0]}) :
             (f3[2] ? v & 32'hFF : {{24{v[7]}}, v[7:0]});
    for (int b = 0; b < 4; b++) begin
      m1[b] = b >= o && b < o + n;
      m2[b] = b < o + n - 4;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    check("ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; nwe = 0;
    cap_addr[2] = 32'h0; cap_mask[2] = 4'h0; cap_wdata[2] = 32'h0;
    while (!resp_valid && lat < 8) begin
      if (lat <= 2) begin
        cap_addr[lat] = mem_addr; cap_mask[lat] = mem_wmask; cap_wdata[lat] = mem_wdata;
      end
      nwe += int'(mem_we);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), mis ? 32'd3 : 32'd2);
    check("rdata", resp_rdata, exp_rd);
    check("err", 32'(resp_err), 32'(err));
    check("we_cycles", 32'(nwe), (we && !err) ? (mis ? 32'd2 : 32'd1) : 32'd0);
    check("addr1", cap_addr[1], {addr[31:2], 2'b00});
    check("mask1", 32'(cap_mask[1]), (we && !err) ? 32'(m1) : 32'd0);
    if (mis) begin
      check("addr2", cap_addr[2], {addr[31:2], 2'b00} + 32'd4);
      check("mask2", 32'(cap_mask[2]), we ? 32'(m2) : 32'd0);
    end
    if (we && !err)
      for (int i = 0; i < n; i++) ref_mem[8'(addr + 32'(i))] = 8'(wd >> (8 * i));
    @(posedge clk); #1;
    check("pulse", 32'(resp_valid), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_mem", mem_addr | mem_wdata | {27'b0, mem_wmask, mem_we}, 32'd0);
    if (we && !err) begin
      a2 = 8'(addr + 32'(n - 1));
      check("mem_lo", dut_mem[addr[7:2]], ref_word(addr[7:0]));
      check("mem_hi", dut_mem[a2[7:2]], ref_word(a2));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    {ref_mem[8'h13], ref_mem[8'h12], ref_mem[8'h11], ref_mem[8'h10]} = 32'h80AABBCC;
    ref_mem[8'h17] = 8'h34;
    ref_mem[8'h18] = 8'h92;
    for (int w = 0; w < 64; w++) dut_mem[w] <= ref_word(8'(w * 4));
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_resp", resp_rdata | {31'b0, resp_err}, 32'd0);
    check("rst_mem", mem_addr | mem_wdata | {27'b0, mem_wmask, mem_we}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    run(1'b0, 3'b000, 32'h13, 32'h0);
    check("lb_sext", resp_rdata, 32'hFFFFFF80);
    run(1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu_zext", resp_rdata, 32'h00000080);
    run(1'b0, 3'b001, 32'h17, 32'h0);
    check("lh_split", resp_rdata, 32'hFFFF9234);
    run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw_wdata", cap_wdata[1], 32'hDEADBEEF);
    check("sw_word", dut_mem[4], 32'hDEADBEEF);
    run(1'b1, 3'b010, 32'h12, 32'h11223344);
    check("msw_mask1", 32'(cap_mask[1]), 32'hC);
    check("msw_wd1", cap_wdata[1], 32'h33440000);
    check("msw_mask2", 32'(cap_mask[2]), 32'h3);
    check("msw_wd2", cap_wdata[2], 32'h00001122);
    run(1'b1, 3'b011, 32'h20, 32'hCAFEF00D);
    check("bad_err", 32'(resp_err), 32'd1);
    run(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    check("wrap_addr", cap_addr[2], 32'h0);
    run(1'b1, 3'b001, 32'hFFFFFFFF, 32'hA5C3);
    // Reset during ACC1: the first-word write lands at the reset edge, the second never does
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h22; req_wdata = 32'h5566_7788;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_acc1_we", 32'(mem_we), 32'd1);
    rst = 1'b0;
    ref_mem[8'h22] = 8'h88;
    ref_mem[8'h23] = 8'h77;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_we", 32'(mem_we), 32'd0);
      check("abort_valid", 32'(resp_valid), 32'd0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_ready", 32'(req_ready), 32'd1);
      check("post_quiet", {30'b0, mem_we, resp_valid}, 32'd0);
    end
    check("abort_lo", dut_mem[8], ref_word(8'h20));
    check("abort_hi", dut_mem[9], ref_word(8'h24));
    for (int k = 0; k < 200; k++)
      run(1'($urandom), 3'($urandom), $urandom, $urandom);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
